// File: rtl/turbo_out_scheduler.sv
`default_nettype none
// ============================================================================
// turbo_out_scheduler : alternating body/tail read scheduler for the turbo
//                       encoder ping-pong output FIFO banks
// Revision 1.0
// ============================================================================
module turbo_out_scheduler #(
  parameter int LEN0 = 1056,
  parameter int LEN1 = 6144,
  parameter int TAIL = 4,
  parameter int CW   = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_done_0,
  input  logic        blk_done_1,
  input  logic        len_flag_0,
  input  logic        len_flag_1,
  input  logic        out_en,
  output logic [1:0]  rd_enc,
  output logic [1:0]  rd_trl,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_tail,
  output logic        out_bank,
  output logic [1:0]  pending,
  output logic        busy,
  output logic        ovf_err,
  output logic [15:0] blk_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_TRL  = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LEN0_M1 = CW'(LEN0 - 1);
  localparam logic [CW-1:0] C_LEN1_M1 = CW'(LEN1 - 1);
  localparam logic [CW-1:0] C_TAIL_M1 = CW'(TAIL - 1);

  state_t        state_q, state_d;
  logic          cur_bank_q, cur_bank_d;
  logic          next_bank_q, next_bank_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pending_q, pending_d;
  logic [1:0]    len_q, len_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   blk_count_q, blk_count_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic          out_tail_q, out_tail_d;
  logic          out_bank_q, out_bank_d;

  logic          w_fire;
  logic          w_blk_end;
  logic          w_other;
  logic [CW-1:0] w_body_last;
  logic [1:0]    w_done;
  logic [1:0]    w_flag;

  always_comb begin
    state_d     = state_q;
    cur_bank_d  = cur_bank_q;
    next_bank_d = next_bank_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    blk_count_d = blk_count_q;
    rd_enc      = 2'b00;
    rd_trl      = 2'b00;

    w_done      = {blk_done_1, blk_done_0};
    w_flag      = {len_flag_1, len_flag_0};
    w_other     = ~cur_bank_q;
    w_fire      = (state_q != S_IDLE) && out_en;
    w_body_last = len_q[cur_bank_q] ? C_LEN1_M1 : C_LEN0_M1;
    w_blk_end   = w_fire && (state_q == S_TRL) && (cnt_q == C_TAIL_M1);

    // A new block landing on the final tail read of the same bank is legal.
    for (int b = 0; b < 2; b++) begin
      if (w_done[b]) begin
        if (pending_q[b] && !(w_blk_end && (cur_bank_q == 1'(b)))) begin
          ovf_d = 1'b1;
        end else begin
          pending_d[b] = 1'b1;
          len_d[b]     = w_flag[b];
        end
      end else if (w_blk_end && (cur_bank_q == 1'(b))) begin
        pending_d[b] = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q[next_bank_q]) begin
          state_d    = S_ENC;
          cur_bank_d = next_bank_q;
          cnt_d      = '0;
        end
      end
      S_ENC: begin
        if (w_fire) begin
          rd_enc[cur_bank_q] = 1'b1;
          if (cnt_q == w_body_last) begin
            cnt_d   = '0;
            state_d = S_TRL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_TRL: begin
        if (w_fire) begin
          rd_trl[cur_bank_q] = 1'b1;
          if (w_blk_end) begin
            next_bank_d = w_other;
            blk_count_d = blk_count_q + 16'd1;
            cnt_d       = '0;
            // Zero-gap hand-over when the other bank is already waiting.
            if (pending_d[w_other]) begin
              state_d    = S_ENC;
              cur_bank_d = w_other;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = w_fire;
    out_sop_d   = w_fire && (state_q == S_ENC) && (cnt_q == '0);
    out_eop_d   = w_blk_end;
    out_tail_d  = w_fire && (state_q == S_TRL);
    out_bank_d  = w_fire ? cur_bank_q : out_bank_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_bank_q  <= 1'b0;
      next_bank_q <= 1'b0;
      cnt_q       <= '0;
      pending_q   <= 2'b00;
      len_q       <= 2'b00;
      ovf_q       <= 1'b0;
      blk_count_q <= 16'd0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_tail_q  <= 1'b0;
      out_bank_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_bank_q  <= cur_bank_d;
      next_bank_q <= next_bank_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      blk_count_q <= blk_count_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_tail_q  <= out_tail_d;
      out_bank_q  <= out_bank_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_tail  = out_tail_q;
  assign out_bank  = out_bank_q;
  assign pending   = pending_q;
  assign busy      = (state_q != S_IDLE);
  assign ovf_err   = ovf_q;
  assign blk_count = blk_count_q;

endmodule
`default_nettype wire

// File: tb/tb_turbo_out_scheduler.sv
`default_nettype none
// ============================================================================
// tb_turbo_out_scheduler : directed + randomized bench with a beat-index model
// Revision 1.0
// ============================================================================
module tb_turbo_out_scheduler;

  localparam int LEN0 = 4;
  localparam int LEN1 = 6;
  localparam int TAIL = 4;
  localparam int CW   = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        blk_done_0 = 1'b0, blk_done_1 = 1'b0;
  logic        len_flag_0 = 1'b0, len_flag_1 = 1'b0;
  logic        out_en = 1'b0;
  logic [1:0]  rd_enc, rd_trl, pending;
  logic        out_valid, out_sop, out_eop, out_tail, out_bank, busy, ovf_err;
  logic [15:0] blk_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each block is a linear run of body+TAIL beats.
  bit m_pend [2];
  bit m_len  [2];
  bit m_next, m_act, m_bank, m_ovf;
  int m_idx, m_cnt;
  bit e_valid, e_sop, e_eop, e_tail, e_bank;

  turbo_out_scheduler #(.LEN0(LEN0), .LEN1(LEN1), .TAIL(TAIL), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .blk_done_0(blk_done_0), .blk_done_1(blk_done_1),
    .len_flag_0(len_flag_0), .len_flag_1(len_flag_1),
    .out_en(out_en),
    .rd_enc(rd_enc), .rd_trl(rd_trl),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_tail(out_tail), .out_bank(out_bank),
    .pending(pending), .busy(busy), .ovf_err(ovf_err), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int body_of(input bit lf);
    return lf ? LEN1 : LEN0;
  endfunction

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0; m_len[0] = 0; m_len[1] = 0;
    m_next = 0; m_act = 0; m_bank = 0; m_ovf = 0; m_idx = 0; m_cnt = 0;
    e_valid = 0; e_sop = 0; e_eop = 0; e_tail = 0; e_bank = 0;
  endtask

  task automatic compare_all();
    bit fire;
    int body;
    logic [1:0] x_enc, x_trl;
    fire  = m_act && out_en;
    body  = body_of(m_len[m_bank]);
    x_enc = (fire && m_idx <  body) ? (2'b01 << m_bank) : 2'b00;
    x_trl = (fire && m_idx >= body) ? (2'b01 << m_bank) : 2'b00;
    check("rd_enc",    32'(rd_enc),    32'(x_enc));
    check("rd_trl",    32'(rd_trl),    32'(x_trl));
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("out_sop",   32'(out_sop),   32'(e_sop));
    check("out_eop",   32'(out_eop),   32'(e_eop));
    check("out_tail",  32'(out_tail),  32'(e_tail));
    if (e_valid) check("out_bank", 32'(out_bank), 32'(e_bank));
    check("pending",   32'(pending),   32'({m_pend[1], m_pend[0]}));
    check("busy",      32'(busy),      32'(m_act));
    check("ovf_err",   32'(ovf_err),   32'(m_ovf));
    check("blk_count", 32'(blk_count), 32'(m_cnt & 16'hFFFF));
  endtask

  task automatic model_update();
    bit fire, finish, old_pend_next;
    bit done [2];
    bit flag [2];
    int body, tot;
    done[0] = blk_done_0; done[1] = blk_done_1;
    flag[0] = len_flag_0; flag[1] = len_flag_1;
    fire   = m_act && out_en;
    body   = body_of(m_len[m_bank]);
    tot    = body + TAIL;
    finish = fire && (m_idx == tot - 1);
    old_pend_next = m_pend[m_next];

    e_valid = fire;
    e_sop   = fire && (m_idx == 0);
    e_tail  = fire && (m_idx >= body);
    e_eop   = finish;
    if (fire) e_bank = m_bank;

    for (int b = 0; b < 2; b++) begin
      bit clr;
      clr = finish && (m_bank == b[0]);
      if (done[b]) begin
        if (m_pend[b] && !clr) m_ovf = 1;
        else begin m_pend[b] = 1; m_len[b] = flag[b]; end
      end else if (clr) begin
        m_pend[b] = 0;
      end
    end

    if (m_act) begin
      if (finish) begin
        m_cnt++;
        m_next = ~m_bank;
        if (m_pend[~m_bank]) begin m_bank = ~m_bank; m_idx = 0; end
        else m_act = 0;
      end else if (fire) begin
        m_idx++;
      end
    end else if (old_pend_next) begin
      m_act = 1; m_bank = m_next; m_idx = 0;
    end
  endtask

  // One clock cycle: inputs applied at negedge, checked, then the edge.
  task automatic cyc(input bit d0, input bit f0, input bit d1, input bit f1, input bit en);
    blk_done_0 = d0; len_flag_0 = f0;
    blk_done_1 = d1; len_flag_1 = f1;
    out_en = en;
    #1;
    compare_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single short block, continuous credit.
    cyc(1, 0, 0, 0, 1);
    repeat (12) cyc(0, 0, 0, 0, 1);
    check("s1_blk_count", 32'(blk_count), 32'd1);

    // Long block on bank 0 then short on bank 1, back to back.
    do_reset();
    cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    repeat (22) cyc(0, 0, 0, 0, 1);
    check("s2_blk_count", 32'(blk_count), 32'd2);

    // Credit toggling during the body.
    do_reset();
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, bit'(i % 2 == 0));

    // Bank 1 arrives first; nothing is served until bank 0 arrives.
    do_reset();
    cyc(0, 0, 1, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 1);
    check("s4_idle", 32'(busy), 32'd0);
    cyc(1, 0, 0, 0, 1);
    repeat (22) cyc(0, 0, 0, 0, 1);

    // Overflow twice mid-drain, then a legal re-arm on the final tail read.
    do_reset();
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 1);
    do_reset();
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      if (m_act && m_idx == LEN0 + TAIL - 1) cyc(1, 1, 0, 0, 1);
      else cyc(0, 0, 0, 0, 1);
    end
    check("s5_no_ovf", 32'(ovf_err), 32'd0);
    check("s5_pend0", 32'(pending), 32'd1);
    cyc(0, 0, 1, 0, 1);
    repeat (30) cyc(0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a body.
    do_reset();
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("s6_mid_idx", 32'(m_idx), 32'd2);
    out_en = 1'b1;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    repeat (12) cyc(0, 0, 0, 0, 1);

    // Randomized traffic and credit.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cyc(bit'($urandom_range(0, 11) == 0), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 11) == 0), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/turbo_out_scheduler.md
Name: turbo_out_scheduler

Overview:
- Read-side scheduler for the turbo encoder's ping-pong output FIFO banks (bank 0/1, each holding a systematic/parity body plus a trellis tail).
- Tracks which banks hold a complete block and drains them in strict alternation, body first, then tail.
- Issues per-bank FIFO read enables paced by a downstream enable, and emits aligned valid/SOP/EOP/tail/bank framing for the output mux.
- Sits between the encoder's write-side bank toggling and the output interface; it replaces ad-hoc read sequencing.

Parameters:
- LEN0, 1056, body length in bits when the latched length flag = 0.
- LEN1, 6144, body length in bits when the latched length flag = 1.
- TAIL, 4, trellis tail reads per block.
- CW, 13, read counter width; must satisfy 2^CW > max(LEN1, TAIL).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- blk_done_0  in  1  one-cycle pulse: bank 0 holds a complete block (body and tail).
- blk_done_1  in  1  one-cycle pulse: bank 1 holds a complete block.
- len_flag_0  in  1  length flag for the bank 0 block; sampled when blk_done_0 = 1.
- len_flag_1  in  1  length flag for the bank 1 block; sampled when blk_done_1 = 1.
- out_en  in  1  downstream permission to issue a read this cycle.
- rd_enc  out  2  body FIFO read enable per bank, combinational.
- rd_trl  out  2  tail FIFO read enable per bank, combinational.
- out_valid  out  1  FIFO data on the output mux is valid this cycle.
- out_sop  out  1  with out_valid: first body bit of a block.
- out_eop  out  1  with out_valid: last tail bit of a block.
- out_tail  out  1  with out_valid: current bit is a tail bit.
- out_bank  out  1  bank supplying the current bit; also the output mux select.
- pending  out  2  per-bank "complete block waiting or being drained" flags.
- busy  out  1  state is not IDLE.
- ovf_err  out  1  sticky: blk_done arrived for an already-pending bank.
- blk_count  out  16  count of fully drained blocks; wraps at 2^16.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE; pending = 0; next_bank = 0; counter = 0; all outputs = 0, including any in-flight out_valid.
- Pending set: blk_done_b = 1 sets pending[b] and latches len_flag_b into len_b.
- Both blk_done pulses in the same cycle are both accepted.
- blk_done_b while pending[b] = 1: set ovf_err; the existing len_b is kept; the pulse is otherwise ignored.
- Exception: if that pulse coincides with the final tail read of bank b, it is a legal new block, not an overflow. Set beats clear, pending[b] stays 1, and len_b reloads.
- States: IDLE, ENC, TRL.
- IDLE -> ENC when pending[next_bank] = 1. Only next_bank is eligible; there is no out-of-order service. Counter = 0. cur_bank = next_bank.
- fire = (state is ENC or TRL) and out_en.
- ENC: rd_enc[cur_bank] = fire. Each fire increments the counter. On the fire with counter = body_len - 1, where body_len = len_b ? LEN1 : LEN0: counter = 0, go to TRL.
- TRL: rd_trl[cur_bank] = fire. On the fire with counter = TAIL - 1:
  - clear pending[cur_bank] (unless set-beats-clear applies);
  - next_bank toggles;
  - blk_count increments;
  - go to ENC of the other bank in the next cycle if it is pending (zero-gap back-to-back), else go to IDLE.
- out_en = 0: no reads are issued; state and counter hold.
- Read latency: one cycle, matching the FIFOs. out_valid, out_sop, out_eop, out_tail and out_bank are the fire-cycle values registered once.
  - out_sop: fire in ENC with counter = 0.
  - out_eop: last TRL fire.
  - out_tail: fire in TRL.
- Data for an issued read always emerges; out_en is a credit, not a stall on returned data.
- At most one bit of rd_enc | rd_trl is high in any cycle.
- Length flag changes after capture have no effect on a block in progress.

Test Plan:
- LEN0=4, LEN1=6, TAIL=4, out_en=1; pulse blk_done_0 with len_flag_0=0 -> rd_enc[0] high 4 cycles, then rd_trl[0] high 4 cycles; out_valid 8 cycles, one cycle later; out_sop on the 1st bit, out_tail on bits 5-8, out_eop on the 8th; pending = 00, blk_count = 1, back to IDLE.
- blk_done_0 (len 1) then blk_done_1 (len 0) two cycles apart -> bank 0: 6+4 reads, immediately followed by bank 1: 4+4 reads with no idle cycle; out_bank 0 for 10 bits then 1 for 8 bits; blk_count = 2.
- out_en toggled 1,0,1,0 during ENC -> reads only on out_en=1 cycles; the counter holds otherwise; total body reads still 4; out_valid pattern is the out_en pattern delayed one cycle.
- blk_done_1 first while next_bank = 0 -> stays IDLE and serves nothing until blk_done_0; bank 0 is drained first, then bank 1.
- blk_done_0 twice while bank 0 is draining (not on its final tail read) -> ovf_err = 1 and stays 1; the original length is used. A blk_done_0 on the exact final tail fire -> no ovf_err, pending[0] remains 1.
- Assert rst = 0 mid-ENC (counter = 2) -> all outputs are 0 in the same cycle, without waiting for a clock edge. After release with no blk_done, the scheduler stays IDLE; a fresh blk_done_0 starts at SOP.
